subtrator_serial_ctrl: RTL and testbench



---
 rtl/subtrator_pkg.sv | 12 +
 rtl/meio_subtrator.sv | 12 +
 rtl/subtrator_completo.sv | 19 +
 rtl/subtrator_serial_ctrl.sv | 94 +++++++++
 tb/tb_subtrator_serial_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/subtrator_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package subtrator_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam int LARGURA_PADRAO = 8;

endpackage

// File: rtl/meio_subtrator.sv
// 1-bit half subtractor: d = a - b, bout set when a borrow is needed.
module meio_subtrator (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

// File: rtl/subtrator_completo.sv
// 1-bit full subtractor from two half subtractors; the borrows are ORed.
module subtrator_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  meio_subtrator u_meio_0 (.a(a),    .b(b),   .d(w_d1), .bout(w_b1));
  meio_subtrator u_meio_1 (.a(w_d1), .b(bin), .d(d),    .bout(w_b2));

  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial N-bit subtractor: sequences one full-subtractor cell over the
// operands LSB first and reports the difference with a one-cycle pronto pulse.
module subtrator_serial_ctrl
  import subtrator_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inicio,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  output logic [LARGURA-1:0] resultado,
  output logic               emprestimo,
  output logic               ocupado,
  output logic               pronto
);

  localparam int CONT_W = $clog2(LARGURA);
  localparam logic [CONT_W-1:0] ULTIMO = CONT_W'(LARGURA - 1);

  estado_t             r_estado;
  logic [LARGURA-1:0]  r_a_sh;
  logic [LARGURA-1:0]  r_b_sh;
  logic [CONT_W-1:0]   r_cont;
  logic                r_borrow;
  logic                w_d;
  logic                w_bout;

  subtrator_completo u_celula (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .bin (r_borrow),
    .d   (w_d),
    .bout(w_bout)
  );

  // Control FSM, operand shifters, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= OCIOSO;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_cont     <= '0;
      r_borrow   <= 1'b0;
      resultado  <= '0;
      emprestimo <= 1'b0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          pronto <= 1'b0;
          if (inicio) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_cont   <= '0;
            r_borrow <= 1'b0;
            ocupado  <= 1'b1;
            r_estado <= CALCULA;
          end else begin
            r_estado <= OCIOSO;
          end
        end
        CALCULA: begin
          resultado[r_cont] <= w_d;
          r_borrow          <= w_bout;
          r_a_sh            <= r_a_sh >> 1;
          r_b_sh            <= r_b_sh >> 1;
          // Leave on the last bit so the counter never wraps.
          if (r_cont == ULTIMO) begin
            emprestimo <= w_bout;
            pronto     <= 1'b1;
            ocupado    <= 1'b0;
            r_estado   <= FIM;
          end else begin
            r_cont   <= r_cont + {{(CONT_W-1){1'b0}}, 1'b1};
            r_estado <= CALCULA;
          end
        end
        FIM: begin
          pronto   <= 1'b0;
          r_estado <= OCIOSO;
        end
        default: begin
          pronto   <= 1'b0;
          ocupado  <= 1'b0;
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
// Directed self-checking bench for subtrator_serial_ctrl with LARGURA=8.
module tb_subtrator_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       inicio;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] resultado;
  logic       emprestimo;
  logic       ocupado;
  logic       pronto;

  int errors = 0;
  int checks = 0;

  subtrator_serial_ctrl #(.LARGURA(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .a         (a),
    .b         (b),
    .resultado (resultado),
    .emprestimo(emprestimo),
    .ocupado   (ocupado),
    .pronto    (pronto)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction from OCIOSO: accept, 8 bit edges, pronto, back to idle.
  task automatic do_sub(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] er, input logic ee);
    a = va;
    b = vb;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    a = ~va;
    b = ~vb;
    chk({tag, "_ocup_t0"}, {7'd0, ocupado}, 8'd1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk({tag, "_pronto_lo"}, {7'd0, pronto}, 8'd0);
      chk({tag, "_ocup_hi"}, {7'd0, ocupado}, 8'd1);
    end
    step();
    chk({tag, "_pronto"}, {7'd0, pronto}, 8'd1);
    chk({tag, "_ocup_lo"}, {7'd0, ocupado}, 8'd0);
    chk({tag, "_res"}, resultado, er);
    chk({tag, "_emp"}, {7'd0, emprestimo}, {7'd0, ee});
    step();
    chk({tag, "_pronto_end"}, {7'd0, pronto}, 8'd0);
    chk({tag, "_res_hold"}, resultado, er);
  endtask

  initial begin
    rst = 1'b1;
    inicio = 1'b0;
    a = 8'h00;
    b = 8'h00;
    step();
    step();
    chk("rst_res", resultado, 8'h00);
    chk("rst_emp", {7'd0, emprestimo}, 8'd0);
    chk("rst_ocup", {7'd0, ocupado}, 8'd0);
    chk("rst_pronto", {7'd0, pronto}, 8'd0);
    rst = 1'b0;
    step();

    do_sub("s05_03", 8'h05, 8'h03, 8'h02, 1'b0);
    do_sub("s03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
    do_sub("s00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
    do_sub("sFF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    do_sub("s80_01", 8'h80, 8'h01, 8'h7F, 1'b0);

    // Held inicio and operand changes during CALCULA must be ignored.
    a = 8'h10;
    b = 8'h01;
    inicio = 1'b1;
    step();
    a = 8'hAA;
    b = 8'h55;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("hold_pronto_lo", {7'd0, pronto}, 8'd0);
      chk("hold_ocup_hi", {7'd0, ocupado}, 8'd1);
    end
    step();
    chk("hold_pronto", {7'd0, pronto}, 8'd1);
    chk("hold_res", resultado, 8'h0F);
    chk("hold_emp", {7'd0, emprestimo}, 8'd0);
    step();
    chk("fim_ignored_ocup", {7'd0, ocupado}, 8'd0);
    chk("fim_ignored_pronto", {7'd0, pronto}, 8'd0);
    step();
    inicio = 1'b0;
    chk("restart_ocup", {7'd0, ocupado}, 8'd1);
    for (int i = 1; i < 8; i++) step();
    step();
    chk("restart_pronto", {7'd0, pronto}, 8'd1);
    chk("restart_res", resultado, 8'h55);
    step();

    // Reset in the middle of CALCULA discards the partial result.
    a = 8'hF0;
    b = 8'h0F;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ocup", {7'd0, ocupado}, 8'd0);
    chk("mid_rst_pronto", {7'd0, pronto}, 8'd0);
    chk("mid_rst_res", resultado, 8'h00);
    chk("mid_rst_emp", {7'd0, emprestimo}, 8'd0);

    // Reset and inicio together: reset wins.
    rst = 1'b1;
    inicio = 1'b1;
    step();
    rst = 1'b0;
    inicio = 1'b0;
    chk("rst_inicio_ocup", {7'd0, ocupado}, 8'd0);
    step();
    chk("rst_inicio_idle", {7'd0, ocupado}, 8'd0);

    do_sub("s09_04", 8'h09, 8'h04, 8'h05, 1'b0);

    // Back-to-back with inicio held: one result every 10 cycles.
    a = 8'h20;
    b = 8'h10;
    inicio = 1'b1;
    step();
    for (int c = 1; c <= 30; c++) begin
      step();
      chk("b2b_pronto", {7'd0, pronto}, ((c % 10) == 8) ? 8'd1 : 8'd0);
      chk("b2b_ocup", {7'd0, ocupado}, ((c % 10) < 8) ? 8'd1 : 8'd0);
      if ((c % 10) == 8) begin
        chk("b2b_res", resultado, 8'h10);
        chk("b2b_emp", {7'd0, emprestimo}, 8'd0);
      end
    end
    inicio = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("drain_ocup", {7'd0, ocupado}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
